// File: rtl/txfifo_pkt_buf.sv
// Transmit packet buffer between the DMA MM2S stream and the link serializer.
// First-word fall-through FIFO with optional store-and-forward gating per packet.
module txfifo_pkt_buf #(
  parameter int unsigned DW       = 32,
  parameter int unsigned UW       = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PKT_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DW-1:0]              s_axis_tdata,
  input  logic [UW-1:0]              s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DW-1:0]              m_axis_tdata,
  output logic [UW-1:0]              m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     pkt_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       oversize_err,
  input  logic                       err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DW + UW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          force_fwd;
  logic          push;
  logic          pop;
  logic          pkt_in;
  logic          pkt_out;
  logic          force_set;

  // Extra pointer MSB separates a full buffer from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty && ((PKT_MODE == 0) || (pkt_cnt != '0) || force_fwd);

  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

  assign push    = s_axis_tvalid && s_axis_tready;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign pkt_in  = push && s_axis_tlast;
  assign pkt_out = pop && m_axis_tlast;

  // A full buffer holding no packet end can never complete one: stream it out.
  assign force_set = full && (pkt_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_cnt      <= '0;
      force_fwd    <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (pkt_in && !pkt_out) begin
        pkt_cnt <= pkt_cnt + PW'(1);
      end else if (pkt_out && !pkt_in) begin
        pkt_cnt <= pkt_cnt - PW'(1);
      end
      if (force_set) begin
        force_fwd <= 1'b1;
      end else if (pkt_out) begin
        force_fwd <= 1'b0;
      end
      if (force_set) begin
        oversize_err <= 1'b1;
      end else if (err_clr) begin
        oversize_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_txfifo_pkt_buf.sv
// Directed bench for txfifo_pkt_buf: store-and-forward instance with an order
// scoreboard, plus a cut-through instance for the fall-through case.
module tb_txfifo_pkt_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned UW = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;

  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [UW-1:0] s_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [UW-1:0] m_tuser;
  logic [PW-1:0] level, pkt_cnt;
  logic          full, empty, oerr, err_clr;

  logic          ct_s_tvalid, ct_s_tready, ct_s_tlast;
  logic [DW-1:0] ct_s_tdata;
  logic [UW-1:0] ct_s_tuser;
  logic          ct_m_tvalid, ct_m_tready, ct_m_tlast;
  logic [DW-1:0] ct_m_tdata;
  logic [UW-1:0] ct_m_tuser;
  logic [PW-1:0] ct_level, ct_pkt_cnt;
  logic          ct_full, ct_empty, ct_oerr;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  logic [DW+UW:0] sb_q[$];

  txfifo_pkt_buf #(.DW(DW), .UW(UW), .DEPTH(DEPTH), .PKT_MODE(1)) u_sf (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .level(level), .pkt_cnt(pkt_cnt), .full(full), .empty(empty),
    .oversize_err(oerr), .err_clr(err_clr)
  );

  txfifo_pkt_buf #(.DW(DW), .UW(UW), .DEPTH(DEPTH), .PKT_MODE(0)) u_ct (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(ct_s_tvalid), .s_axis_tready(ct_s_tready), .s_axis_tdata(ct_s_tdata),
    .s_axis_tuser(ct_s_tuser), .s_axis_tlast(ct_s_tlast),
    .m_axis_tvalid(ct_m_tvalid), .m_axis_tready(ct_m_tready), .m_axis_tdata(ct_m_tdata),
    .m_axis_tuser(ct_m_tuser), .m_axis_tlast(ct_m_tlast),
    .level(ct_level), .pkt_cnt(ct_pkt_cnt), .full(ct_full), .empty(ct_empty),
    .oversize_err(ct_oerr), .err_clr(1'b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a beat on s_axis until accepted; returns just after the accepting edge.
  task automatic push_beat(input logic [DW-1:0] d, input logic last);
    bit ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = d[7:0] ^ 8'h5A;
    s_tlast  = last;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = s_tready;
      step();
    end
    s_tvalid = 1'b0;
    chk("push_ack", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (empty && sb_q.size() == 0) ok = 1'b1;
      else step();
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  // Order scoreboard: handshakes sampled mid-cycle, completed at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        pop_cnt++;
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) chk("sb_order", 64'({m_tlast, m_tuser, m_tdata}), 64'(sb_q.pop_front()));
      end
      if (s_tvalid && s_tready) sb_q.push_back({s_tlast, s_tuser, s_tdata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tlast = 1'b0;
    m_tready = 1'b0; err_clr = 1'b0;
    ct_s_tvalid = 1'b0; ct_s_tdata = '0; ct_s_tuser = '0; ct_s_tlast = 1'b0; ct_m_tready = 1'b0;
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_oerr", 64'(oerr), 64'd0);
    #11 rst_n = 1'b1;
    step();

    // 3-beat packet held until its last beat lands
    m_tready = 1'b1;
    push_beat(32'd101, 1'b0);
    chk("sf_hold1", 64'(m_tvalid), 64'd0);
    push_beat(32'd102, 1'b0);
    chk("sf_hold2", 64'(m_tvalid), 64'd0);
    push_beat(32'd103, 1'b1);
    chk("sf_release", 64'(m_tvalid), 64'd1);
    chk("sf_pkt1", 64'(pkt_cnt), 64'd1);
    chk("sf_head", 64'(m_tdata), 64'd101);
    step();
    chk("sf_beat2", 64'(m_tdata), 64'd102);
    step();
    chk("sf_beat3", 64'(m_tdata), 64'd103);
    chk("sf_last3", 64'(m_tlast), 64'd1);
    chk("sf_pkt_before", 64'(pkt_cnt), 64'd1);
    step();
    chk("sf_pkt0", 64'(pkt_cnt), 64'd0);
    chk("sf_empty", 64'(empty), 64'd1);
    chk("sf_vld0", 64'(m_tvalid), 64'd0);

    // cut-through single beat
    ct_s_tvalid = 1'b1; ct_s_tdata = 32'hA5A5A5A5; ct_s_tuser = 8'h3C; ct_s_tlast = 1'b1;
    chk("ct_no_bypass", 64'(ct_m_tvalid), 64'd0);
    chk("ct_s_tready", 64'(ct_s_tready), 64'd1);
    step();
    ct_s_tvalid = 1'b0;
    chk("ct_vld", 64'(ct_m_tvalid), 64'd1);
    chk("ct_data", 64'(ct_m_tdata), 64'hA5A5A5A5);
    chk("ct_user", 64'(ct_m_tuser), 64'h3C);
    chk("ct_last", 64'(ct_m_tlast), 64'd1);
    chk("ct_level1", 64'(ct_level), 64'd1);
    chk("ct_pkt1", 64'(ct_pkt_cnt), 64'd1);
    ct_m_tready = 1'b1;
    step();
    ct_m_tready = 1'b0;
    chk("ct_level0", 64'(ct_level), 64'd0);
    chk("ct_empty", 64'(ct_empty), 64'd1);
    chk("ct_vld0", 64'(ct_m_tvalid), 64'd0);
    chk("ct_full", 64'(ct_full), 64'd0);
    chk("ct_oerr", 64'(ct_oerr), 64'd0);

    // fill to DEPTH with single-beat packets
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) push_beat(32'(200 + i), 1'b1);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_s_tready", 64'(s_tready), 64'd0);
    chk("fill_pkt_cnt", 64'(pkt_cnt), 64'd16);
    chk("fill_level", 64'(level), 64'd16);
    step();
    chk("fill_no_oerr", 64'(oerr), 64'd0);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("pop1_s_tready", 64'(s_tready), 64'd1);
    chk("pop1_level", 64'(level), 64'd15);
    chk("pop1_pkt_cnt", 64'(pkt_cnt), 64'd15);
    m_tready = 1'b1;
    wait_drain();

    // steady push+pop at level 5 across pointer wrap
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) push_beat(32'(300 + i), 1'b1);
    chk("lvl5_fill", 64'(level), 64'd5);
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tlast = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tdata = 32'(305 + i);
      s_tuser = s_tdata[7:0] ^ 8'h5A;
      step();
      chk("lvl5_hold", 64'(level), 64'd5);
    end
    s_tvalid = 1'b0;
    wait_drain();

    // 20-beat packet overflows the buffer and is forced out
    pop_cnt = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) push_beat(32'(400 + i), 1'b0);
    chk("ovr_full", 64'(full), 64'd1);
    chk("ovr_held", 64'(m_tvalid), 64'd0);
    chk("ovr_oerr_pre", 64'(oerr), 64'd0);
    step();
    chk("ovr_oerr", 64'(oerr), 64'd1);
    chk("ovr_forced", 64'(m_tvalid), 64'd1);
    for (int i = 16; i < 20; i++) push_beat(32'(400 + i), i == 19);
    wait_drain();
    chk("ovr_pops", 64'(pop_cnt), 64'd20);
    chk("ovr_vld0", 64'(m_tvalid), 64'd0);
    chk("ovr_sticky", 64'(oerr), 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovr_clr", 64'(oerr), 64'd0);

    // asynchronous reset with 7 beats stored
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) push_beat(32'(500 + i), 1'b1);
    chk("ar_level7", 64'(level), 64'd7);
    chk("ar_vld1", 64'(m_tvalid), 64'd1);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("ar_level", 64'(level), 64'd0);
    chk("ar_empty", 64'(empty), 64'd1);
    chk("ar_vld", 64'(m_tvalid), 64'd0);
    chk("ar_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("ar_s_tready", 64'(s_tready), 64'd1);
    step();
    rst_n = 1'b1;
    m_tready = 1'b1;
    push_beat(32'd600, 1'b0);
    chk("post_rst_hold", 64'(m_tvalid), 64'd0);
    push_beat(32'd601, 1'b1);
    chk("post_rst_head", 64'(m_tdata), 64'd600);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/txfifo_pkt_buf.md
TXFIFO_PKT_BUF -- requirements
Module: txfifo_pkt_buf

Interface
REQ-001 Parameter DW, default 32: stream data width, equal to TXFIFO_STRM_DW.
REQ-002 Parameter UW, default 8: tuser width, equal to TXFIFO_STRM_UW.
REQ-003 Parameter DEPTH, default 16: entries, power of two, at least 4.
REQ-004 Parameter PKT_MODE, default 1: 1 = store-and-forward, 0 = cut-through.
REQ-005 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- s_axis_tvalid  in  1  beat from the DMA MM2S stream (the DMA's txfifo stream producer).
- s_axis_tready  out  1  accept.
- s_axis_tdata  in  DW  data.
- s_axis_tuser  in  UW  sideband.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  beat to the link serializer.
- m_axis_tready  in  1  accept.
- m_axis_tdata  out  DW  data.
- m_axis_tuser  out  UW  sideband.
- m_axis_tlast  out  1  end of packet.
- level  out  $clog2(DEPTH)+1  stored beats.
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets stored.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- oversize_err  out  1  sticky: a packet exceeded DEPTH.
- err_clr  in  1  one-cycle pulse; clears oversize_err.

Function
REQ-010 Storage: circular buffer of DEPTH entries {tdata, tuser, tlast}; write and read pointers each $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; MSB difference distinguishes full from empty.
REQ-011 push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready.
REQ-012 s_axis_tready = !full, combinational from registered state; no same-cycle pop-through when full.
REQ-013 First-word fall-through: a beat pushed in cycle N is presentable on m_axis in cycle N+1 at the earliest; no combinational path from s_axis to m_axis.
REQ-014 m_axis_tdata/tuser/tlast = entry at the read pointer; they hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 Level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-016 pkt_cnt: +1 on push with tlast=1, -1 on pop with tlast=1, unchanged when both occur in the same cycle.
REQ-017 PKT_MODE=0: m_axis_tvalid = !empty.
REQ-018 PKT_MODE=1: m_axis_tvalid = !empty & (pkt_cnt!=0 | force).
REQ-019 force is a register:
- set when full=1 and pkt_cnt==0;
- cleared on a pop with m_axis_tlast=1.
REQ-020 oversize_err is set in the same cycle force is set.
REQ-021 oversize_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
REQ-022 Once m_axis_tvalid is asserted, it shall not deassert until pop.

Reset
REQ-030 On rst_n low, asynchronously:
- pointers, level, pkt_cnt, force and oversize_err = 0;
- empty=1, full=0;
- m_axis_tvalid=0, s_axis_tready=1.
REQ-031 Reset mid-packet discards all stored beats; the first beat after release starts a new packet.
REQ-032 Memory contents are not reset; m_axis_tdata is don't-care while m_axis_tvalid=0.

Verification
REQ-040 PKT_MODE=1: push a 3-beat packet (last on beat 3) with m_axis_tready=1 -> m_axis_tvalid=0 until the cycle after beat 3; then 3 pops in order; pkt_cnt goes 1 then 0.
REQ-041 PKT_MODE=0: single beat 0xA5A5A5A5 -> appears on m_axis the next cycle; level returns 0 after pop.
REQ-042 Fill to DEPTH=16 with m_axis_tready=0 and tlast on every beat -> full=1, s_axis_tready=0, pkt_cnt=16; then a single pop -> s_axis_tready=1 the next cycle.
REQ-043 Continuous push and pop at level 5 for 100 cycles -> level stays 5; output order is preserved through pointer wrap.
REQ-044 PKT_MODE=1: 20-beat packet -> at beat 16 force=1 and oversize_err=1; all 20 beats drain in order; err_clr pulse -> oversize_err=0.
REQ-045 rst_n low for one cycle with 7 beats stored -> level=0, empty=1, m_axis_tvalid=0 immediately, without waiting for a clock edge.
